// File: rtl/pipe_stage_skid.sv
// Pipeline stage register (data/ctrl/pc) with valid/ready handshake and a 2-entry skid buffer.
// Latency: 1 cycle from in_fire to out_valid; one transfer per cycle while out_ready stays high.
// Backpressure: in_ready drops only when the skid entry is occupied; it depends on registers and rst alone.
module pipe_stage_skid #(
    parameter int DATA_W = 192,
    parameter int CTRL_W = 22,
    parameter int PC_W   = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [PC_W-1:0]   in_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [PC_W-1:0]   out_pc,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef struct packed {
        logic [DATA_W-1:0] dat;
        logic [CTRL_W-1:0] ctrl;
        logic [PC_W-1:0]   pc;
    } entry_t;

    // Encoding doubles as the occupancy count.
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    logic [1:0]       state_q, state_d;
    entry_t           main_q, main_d;
    entry_t           skid_q, skid_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic   out_vld;
    logic   skid_vld;
    logic   in_fire;
    logic   out_fire;
    entry_t in_ent;

    assign out_vld  = (state_q != ST_EMPTY);
    assign skid_vld = (state_q == ST_FULL);
    assign in_ready = !rst && !skid_vld;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_vld && out_ready;
    assign in_ent   = '{dat: in_data, ctrl: in_ctrl, pc: in_pc};

    assign out_valid = out_vld;
    assign out_data  = main_q.dat;
    assign out_pc    = main_q.pc;
    assign out_ctrl  = out_vld ? main_q.ctrl : '0;
    assign occupancy = state_q;
    assign stall_cnt = stall_cnt_q;

    always_comb begin
        state_d     = state_q;
        main_d      = main_q;
        skid_d      = skid_q;
        stall_cnt_d = stall_cnt_q;

        // Counts the flush cycle too; flush never touches the counter.
        if (out_vld && !out_ready && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end

        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state_d = ST_ONE;
                        main_d  = in_ent;
                    end
                end
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        main_d = in_ent;
                    end else if (in_fire) begin
                        state_d = ST_FULL;
                        skid_d  = in_ent;
                    end else if (out_fire) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (out_fire) begin
                        state_d = ST_ONE;
                        main_d  = skid_q;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule
